key_fifo: RTL
=============

Name: key_fifo

Overview:
Downstream consumer of the 16-key priority encoder's key_in/key_val outputs. Synchronises those outputs and debounces them. On each accepted press (one event per press-and-release) it pushes the 4-bit key code into a small FIFO, which the CPU-side or display logic drains through a valid/ready handshake. Sticky overflow flag for presses lost while full.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive synced clocks of stable input required to accept a press or a release (>=2); counter width $clog2(DEBOUNCE_CYCLES+1).
DEPTH, 4, FIFO entries; power of two, >=2.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
key_in  input  1  any-key-pressed from encoder (asynchronous to clk)
key_val  input  4  encoded key code from encoder, meaningful only when key_in=1
out_ready  input  1  consumer accepts out_data this cycle
clr_ovf  input  1  synchronous clear of overflow
out_valid  output  1  FIFO non-empty
out_data  output  4  head-of-FIFO key code
level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky: a press was dropped because FIFO was full

Behaviour:
- Reset (rst_n=0, async): sync flops 0, FSM=IDLE, counter 0, FIFO pointers 0, out_valid=0, out_data=0, level=0, overflow=0. Reset mid-debounce or mid-drain discards all state; no push follows reset release unless a fresh full debounce completes.
- Sync: key_in and key_val each pass through 2 flops -> s_in, s_val. All logic below uses s_in/s_val only.
- FSM states IDLE, PRESS_WAIT, HELD, REL_WAIT; cnt counter; cap = 4-bit captured code.
- IDLE: s_in=1 -> cap<=s_val, cnt<=1, go PRESS_WAIT.
- PRESS_WAIT: s_in=0 -> IDLE, cnt<=0. Else if s_val!=cap -> cap<=s_val, cnt<=1, stay (restart). Else if cnt==DEBOUNCE_CYCLES-1 -> push cap, cnt<=0, go HELD. Else cnt++.
- HELD: s_in=0 -> cnt<=1, go REL_WAIT. Code changes while held (second key / key roll) do NOT push; a new press requires a full release.
- REL_WAIT: s_in=1 -> HELD, cnt<=0. Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0. Else cnt++.
- Latency: inputs stable from before edge 0 -> s_in valid after edge 2 -> push occurs on edge DEBOUNCE_CYCLES+2 -> out_valid=1 and out_data=code visible immediately after that edge (when FIFO was empty). No empty-FIFO bypass.
- FIFO: circular buffer with DEPTH entries. out_valid=(level!=0). out_data=mem[rd_ptr], registered storage, valid whenever out_valid=1. Pop when out_valid&&out_ready. out_ready while empty is ignored.
- Push while full without a same-cycle pop: entry dropped, FIFO unchanged, overflow<=1.
- Push and pop in the same cycle: both performed, level unchanged. When full, this is not an overflow.
- Pointers wrap modulo DEPTH; level never exceeds DEPTH and never goes below 0.
- overflow: set has priority over clr_ovf in the same cycle; otherwise clr_ovf=1 -> 0 next edge.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4):
1. Reset, then key_in=1, key_val=4'hA held 20 cycles, out_ready=0 -> exactly one entry; out_valid rises on edge 6 after stimulus; out_data=A, level=1; no further push while held.
2. Glitch: key_in=1 for 3 cycles then 0, repeated 5 times -> no push, level=0. Value bounce: key_val alternates 3/5 each cycle with key_in=1, then settles at 5 -> single push of 5 after 4 stable synced cycles.
3. Release bounce: press 7 accepted, key_in drops 2 cycles, returns 2 cycles, then released for good -> only one 7 pushed; a second clean press of 7 afterwards pushes a second 7.
4. Five clean presses 1,2,3,4,5 with out_ready=0 -> level=4, contents 1,2,3,4, overflow=1. Pulse clr_ovf -> overflow=0. Drain with out_ready=1 -> 1,2,3,4 on consecutive cycles, then out_valid=0.
5. FIFO full (level=4) with out_ready=1 on the cycle press F pushes -> level stays 4, overflow stays 0, F appears as fourth entry after the pop. Continuous pushes and pops across more than 8 entries verify pointer wrap and order.
6. Assert rst_n=0 mid-PRESS_WAIT and while level=2 -> all outputs 0 immediately (async). Deassert with key still held -> push occurs only after the full DEBOUNCE_CYCLES+2 latency.

Source files
------------

// File: rtl/key_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_fifo: synchronise and debounce encoder key presses into a small FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_fifo #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEPTH           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     key_in,
  input  logic [3:0]               key_val,
  input  logic                     out_ready,
  input  logic                     clr_ovf,
  output logic                     out_valid,
  output logic [3:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  logic          in_meta_q, in_sync_q;
  logic [3:0]    val_meta_q, val_sync_q;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cap_q, cap_d;
  logic          push;

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          pop, full, wr_en, drop;

  // Two-flop synchronisers; key_val is only sampled once key_in agrees with it
  // for the whole debounce window, so bit-skew across the bus is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta_q  <= 1'b0;
      in_sync_q  <= 1'b0;
      val_meta_q <= 4'h0;
      val_sync_q <= 4'h0;
    end else begin
      in_meta_q  <= key_in;
      in_sync_q  <= in_meta_q;
      val_meta_q <= key_val;
      val_sync_q <= val_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_sync_q) begin
          cap_d   = val_sync_q;
          cnt_d   = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!in_sync_q) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (val_sync_q != cap_q) begin
          cap_d = val_sync_q;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        // Code changes while held are ignored: a new event needs a full release.
        if (!in_sync_q) begin
          cnt_d   = CNT_ONE;
          state_d = REL_WAIT;
        end
      end
      REL_WAIT: begin
        if (in_sync_q) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop   = out_valid && out_ready;
  assign full  = (level_q == LVL_FULL);
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 4'h0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= cap_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // A drop in the same cycle as a clear wins, so no lost press goes unflagged.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire
